// File: rtl/a_sram_reader.sv
// Read-side master for the 16-bank A-operand SRAM: streams a run of rows out over valid/ready.
// Optional macro A_READER_TAG_STRIP_EN zeroes each bank's tag byte on out_data and adds tag_err.
module a_sram_reader #(
  parameter int BANKS  = 16,
  parameter int WORD_W = 264,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [ADDR_W:0]           num_words,
  output logic                      busy,
  output logic                      done,
  output logic                      rd_en,
  output logic [ADDR_W-1:0]         rd_addr,
  input  logic [BANKS*WORD_W-1:0]   rd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BANKS*WORD_W-1:0]   out_data,
  output logic                      out_last
`ifdef A_READER_TAG_STRIP_EN
  ,
  output logic                      tag_err
`endif
);

  localparam int ROW_W = BANKS * WORD_W;
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W-1:0] next_addr;
  logic              accept;
  logic              credit_ok;
  logic              last_issue;

  logic              rd_vld_p1;
  logic              rd_last_p1;

  logic [ROW_W-1:0]  fifo_data [2];
  logic [1:0]        fifo_last;
  logic [1:0]        fifo_cnt;
  logic              wr_ptr, rd_ptr;
  logic              head_in_fifo;
  logic [ROW_W-1:0]  head_data;
  logic              head_last;
  logic              pop, push_store, pop_store;

`ifdef A_READER_TAG_STRIP_EN
  function automatic logic [ROW_W-1:0] strip_tags(input logic [ROW_W-1:0] row);
    logic [ROW_W-1:0] r;
    r = row;
    for (int b = 0; b < BANKS; b++) r[b*WORD_W + WORD_W-8 +: 8] = 8'h00;
    return r;
  endfunction

  function automatic logic tags_differ(input logic [ROW_W-1:0] row);
    logic d;
    d = 1'b0;
    for (int b = 1; b < BANKS; b++)
      if (row[b*WORD_W + WORD_W-8 +: 8] != row[WORD_W-8 +: 8]) d = 1'b1;
    return d;
  endfunction
`endif

  assign accept     = start && (state == S_IDLE);
  // Counting stored entries plus the row arriving this cycle keeps the 2-entry FIFO from overflowing.
  assign credit_ok  = ({1'b0, rd_vld_p1} + fifo_cnt) < 2'd2;
  assign last_issue = rd_en && (remaining == (ADDR_W+1)'(1));
  assign next_addr  = (rd_addr == LAST_ADDR) ? '0 : rd_addr + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_ISSUE;
      S_ISSUE: if (last_issue) state_nxt = S_DRAIN;
      S_DRAIN: if ((fifo_cnt == 2'd0) && !rd_vld_p1) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    rd_en = 1'b0;
    case (state)
      S_ISSUE: begin
        busy  = 1'b1;
        rd_en = (remaining != '0) && credit_ok;
      end
      S_DRAIN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Stage p0: address / run-length bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr   <= '0;
      remaining <= '0;
    end else if (accept) begin
      rd_addr   <= base_addr;
      remaining <= (num_words == '0) ? DEPTH_CNT : num_words;
    end else if (rd_en) begin
      rd_addr   <= next_addr;
      remaining <= remaining - 1'b1;
    end
  end

  // Stage p1: SRAM data valid, one cycle after the strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_p1  <= 1'b0;
      rd_last_p1 <= 1'b0;
    end else begin
      rd_vld_p1  <= rd_en;
      rd_last_p1 <= last_issue;
    end
  end

  // An empty FIFO forwards the arriving row directly, so a ready sink sees one row per cycle.
  assign head_in_fifo = (fifo_cnt != 2'd0);
  assign out_valid    = head_in_fifo || rd_vld_p1;
  assign head_data    = head_in_fifo ? fifo_data[rd_ptr] : rd_data;
  assign head_last    = head_in_fifo ? fifo_last[rd_ptr] : rd_last_p1;
  assign pop          = out_valid && out_ready;
  assign pop_store    = pop && head_in_fifo;
  assign push_store   = rd_vld_p1 && !(pop && !head_in_fifo);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_cnt  <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      fifo_last <= 2'b00;
    end else begin
      if (push_store) begin
        fifo_last[wr_ptr] <= rd_last_p1;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop_store) rd_ptr <= ~rd_ptr;
      case ({push_store, pop_store})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_store) fifo_data[wr_ptr] <= rd_data;
  end

  // Stage p2: output presentation
`ifdef A_READER_TAG_STRIP_EN
  assign out_data = out_valid ? strip_tags(head_data) : '0;
  assign tag_err  = pop && tags_differ(head_data);
`else
  assign out_data = out_valid ? head_data : '0;
`endif
  assign out_last = out_valid && head_last;

endmodule

// File: tb/tb_a_sram_reader.sv
// Directed bench for a_sram_reader: SRAM model, stream scoreboard, credit/hold/timing checks.
module tb_a_sram_reader;

  localparam int BANKS  = 16;
  localparam int WORD_W = 264;
  localparam int ROW_W  = BANKS * WORD_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [6:0]       base_addr = '0;
  logic [7:0]       num_words = '0;
  logic             busy, done, rd_en;
  logic [6:0]       rd_addr;
  logic [ROW_W-1:0] rd_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ROW_W-1:0] out_data;
  logic             out_last;
`ifdef A_READER_TAG_STRIP_EN
  logic             tag_err;
`endif

  int n_chk = 0;
  int n_err = 0;

  a_sram_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_words(num_words),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
`ifdef A_READER_TAG_STRIP_EN
    , .tag_err(tag_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  bit corrupt_en = 1'b0;

  function automatic logic [ROW_W-1:0] sram_row(input int a, input bit corrupt);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int b = 0; b < BANKS; b++) begin
      for (int j = 0; j < 32; j++) r[b*WORD_W + j*8 +: 8] = 8'(a*7 + b*13 + j*3 + 1);
      r[b*WORD_W + 256 +: 8] = 8'(a) ^ 8'h5A;
      if (corrupt && a == 10 && b == 3) r[b*WORD_W + 256 +: 8] = 8'(a) ^ 8'hA5;
    end
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] exp_row(input int a);
    logic [ROW_W-1:0] r;
    r = sram_row(a, 1'b0);
`ifdef A_READER_TAG_STRIP_EN
    for (int b = 0; b < BANKS; b++) r[b*WORD_W + 256 +: 8] = 8'h00;
`endif
    return r;
  endfunction

  function automatic logic [63:0] fold(input logic [ROW_W-1:0] r);
    logic [63:0] acc;
    acc = '0;
    for (int k = 0; k < ROW_W/64; k++) acc = {acc[62:0], acc[63]} ^ r[k*64 +: 64];
    return acc;
  endfunction

  // One-cycle-latency SRAM
  always @(posedge clk) if (rd_en) rd_data <= sram_row(int'(rd_addr), corrupt_en);

  logic [7:0]  q[$];
  logic [7:0]  e;
  int          ncyc = 0, occ = 0, infl = 0;
  int          start_cyc = 0, first_hs = -1, last_hs = -100, done_cnt = 0;
  bit          running = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
  bit          pop, exp_done, accept, te_exp;
  logic [63:0] prev_fold = '0;
  logic [6:0]  exp_addr = '0;
  logic [7:0]  tag_or;

  always @(negedge clk) begin
    ncyc++;
    if (!rst_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_data", out_data != '0, 0);
`ifdef A_READER_TAG_STRIP_EN
      chk("rst_tag_err", tag_err, 0);
`endif
      occ = 0; infl = 0; running = 1'b0; prev_stall = 1'b0; last_hs = -100;
      q.delete();
    end else begin
      pop = out_valid && out_ready;
      te_exp = 1'b0;
      chk("out_valid", out_valid, (occ != 0) || (infl != 0));
      if (rd_en) begin
        chk("credit", (infl + occ) < 2, 1);
        chk("rd_addr", rd_addr, exp_addr);
        exp_addr = exp_addr + 7'd1;
      end
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", fold(out_data), prev_fold);
        chk("hold_last", out_last, prev_last);
      end
      exp_done = (ncyc == last_hs + 2);
      chk("done", done, exp_done);
      chk("busy", busy, running && !exp_done);
      if (done) done_cnt++;
      if (pop) begin
        if (q.size() == 0) chk("extra_row", 1, 0);
        else begin
          e = q.pop_front();
          chk("row_data", fold(out_data), fold(exp_row(int'(e[6:0]))));
          chk("row_last", out_last, e[7]);
          te_exp = corrupt_en && (e[6:0] == 7'd10);
`ifdef A_READER_TAG_STRIP_EN
          tag_or = '0;
          for (int b = 0; b < BANKS; b++) tag_or = tag_or | out_data[b*WORD_W + 256 +: 8];
          chk("tag_stripped", tag_or, 0);
`endif
          if (first_hs < 0) first_hs = ncyc;
          if (e[7]) last_hs = ncyc;
        end
      end
`ifdef A_READER_TAG_STRIP_EN
      chk("tag_err", tag_err, te_exp);
`endif
      accept = start && !running;
      if (exp_done) running = 1'b0;
      if (accept) begin
        running = 1'b1; start_cyc = ncyc; exp_addr = base_addr; first_hs = -1;
      end
      prev_stall = out_valid && !out_ready;
      prev_fold  = fold(out_data);
      prev_last  = out_last;
      occ  = occ + infl - (pop ? 1 : 0);
      infl = rd_en ? 1 : 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int base, input int num, input bit rnd, input bit collide);
    int n, d0, waited;
    n = (num == 0) ? 128 : num;
    d0 = done_cnt;
    waited = 0;
    for (int i = 0; i < n; i++) q.push_back({1'(i == n-1), 7'((base + i) % 128)});
    out_ready = 1'b1;
    base_addr = 7'(base);
    num_words = 8'(num);
    start = 1'b1;
    tick();
    start = 1'b0;
    base_addr = 7'd0;
    num_words = 8'd1;
    while (done_cnt == d0 && waited < 2000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (collide && waited == 3) begin
        start = 1'b1; base_addr = 7'd77; num_words = 8'd2;
      end else start = 1'b0;
      tick();
      waited++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("done_seen", done_cnt != d0, 1);
    repeat (4) tick();
    chk("done_once", done_cnt - d0, 1);
    chk("rows_left", q.size(), 0);
  endtask

  initial begin
    // Reset with random stimulus on the inputs
    repeat (6) begin
      start = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    start = 1'b0;
    rst_n = 1'b1;
    tick();

    // Full 128-row sweep at one row per cycle
    run(0, 128, 1'b0, 1'b0);
    chk("first_latency", first_hs - start_cyc, 2);
    chk("stream_span", last_hs - first_hs, 127);

    // num_words == 0 means a full DEPTH run
    run(64, 0, 1'b0, 1'b0);
    chk("zero_span", last_hs - first_hs, 127);

    // Address wrap 127 -> 0
    run(120, 16, 1'b0, 1'b0);

    // Random backpressure
    run(33, 8, 1'b1, 1'b0);
    run(126, 5, 1'b1, 1'b0);

    // Start while busy is ignored
    run(40, 8, 1'b0, 1'b1);

    // Mid-run abort, then a fresh short run
    for (int i = 0; i < 8; i++) q.push_back({1'(i == 7), 7'(50 + i)});
    out_ready = 1'b0;
    base_addr = 7'd50; num_words = 8'd8; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    run(5, 3, 1'b0, 1'b0);

`ifdef A_READER_TAG_STRIP_EN
    corrupt_en = 1'b1;
    run(8, 4, 1'b0, 1'b0);
    run(9, 3, 1'b1, 1'b0);
    corrupt_en = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
